// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: digit width, per-digit radix
// (ten-second and ten-minute digits count 0..5) and the count-direction enum.
package stopwatch_pkg;

  localparam int DIG_W = 4;

  typedef enum logic {
    MODE_UP = 1'b0,
    MODE_DN = 1'b1
  } mode_e;

  function automatic int radix(input int i);
    return ((i == 3) || (i == 5)) ? 6 : 10;
  endfunction

  // Clamp an out-of-range preset digit to the largest value its position allows.
  function automatic logic [DIG_W-1:0] sat_digit(input logic [DIG_W-1:0] v, input int i);
    logic [DIG_W-1:0] top_v;
    top_v = DIG_W'(radix(i) - 1);
    return (v > top_v) ? top_v : v;
  endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One cascadable BCD digit counting 0..RADIX-1 in either direction; lim flags
// the value at which the next enable carries (up) or borrows (down).
module stopwatch_digit
  import stopwatch_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_e            dir,
  input  logic             clr,
  input  logic             ld,
  input  logic [DIG_W-1:0] ld_val,
  output logic [DIG_W-1:0] q,
  output logic             lim
);

  localparam logic [DIG_W-1:0] QMAX = DIG_W'(RADIX - 1);

  // Digit register: clear and load win over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      if (dir == MODE_UP) begin
        q <= (q == QMAX) ? 4'd0 : q + 4'd1;
      end else begin
        q <= (q == 4'd0) ? QMAX : q - 4'd1;
      end
    end
  end

  // Carry/borrow-out condition for the current direction.
  always_comb begin
    if (dir == MODE_UP) begin
      lim = (q == QMAX);
    end else begin
      lim = (q == 4'd0);
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch / countdown timer with prescaler, split hold and preset load.
// Optional sticky overflow output ovf is built when STOPWATCH_OVF_EN is defined.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int NDIG     = 6,
  parameter int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  b_run,
  input  logic                  b_clr,
  input  logic                  mode,
  input  logic                  ld,
  input  logic [DIG_W*NDIG-1:0] ld_bcd,
  output logic [DIG_W*NDIG-1:0] dsp_bcd,
  output logic                  s_run,
  output logic                  s_hld,
  output logic                  tick,
  output logic                  done,
  output logic                  wrap
`ifdef STOPWATCH_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int              CW        = DIG_W * NDIG;
  localparam logic [TDW-1:0]  PRESC_MAX = TDW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  logic            run_r, hld_r, done_r, wrap_r;
  mode_e           mode_r, mode_in_s;
  logic [TDW-1:0]  presc_r;
  logic [CW-1:0]   hold_r, preset_r, count_s, ld_sat_s, dig_ld_val_s;
  logic [NDIG-1:0] lim_s, en_s;
  logic            tick_s, clr_ev_s, ld_ev_s, clr_stop_s, dig_clr_s, dig_ld_s;
  logic            wrap_ev_s, zero_ev_s, start_ok_s;

  // Saturate every preset digit to its radix.
  always_comb begin
    ld_sat_s = {CW{1'b0}};
    for (int i = 0; i < NDIG; i++) begin
      ld_sat_s[i*DIG_W +: DIG_W] = sat_digit(ld_bcd[i*DIG_W +: DIG_W], i);
    end
  end

  // Button decode: b_run beats b_clr, and ld yields to both and to running.
  always_comb begin
    mode_in_s  = mode_e'(mode);
    clr_ev_s   = b_clr & ~b_run;
    ld_ev_s    = ld & ~b_run & ~b_clr & ~run_r;
    clr_stop_s = clr_ev_s & ~run_r & ~hld_r;
    dig_clr_s  = clr_stop_s & (mode_in_s == MODE_UP);
    dig_ld_s   = ld_ev_s | (clr_stop_s & (mode_in_s == MODE_DN));
    if (ld_ev_s) begin
      dig_ld_val_s = ld_sat_s;
    end else begin
      dig_ld_val_s = preset_r;
    end
    tick_s     = run_r & (presc_r == PRESC_MAX);
    wrap_ev_s  = tick_s & (mode_r == MODE_UP) & (&lim_s);
    zero_ev_s  = tick_s & (mode_r == MODE_DN) & (count_s == CNT_ONE);
    start_ok_s = ~((mode_in_s == MODE_DN) & (count_s == {CW{1'b0}}));
  end

  assign en_s[0] = tick_s;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    stopwatch_digit #(.RADIX(radix(g))) u_digit (
      .clk    (clk),
      .rst    (rst),
      .en     (en_s[g]),
      .dir    (mode_r),
      .clr    (dig_clr_s),
      .ld     (dig_ld_s),
      .ld_val (dig_ld_val_s[g*DIG_W +: DIG_W]),
      .q      (count_s[g*DIG_W +: DIG_W]),
      .lim    (lim_s[g])
    );
    if (g < NDIG - 1) begin : g_chain
      assign en_s[g+1] = en_s[g] & lim_s[g];
    end
  end

  // Run/hold control, prescaler, preset and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r    <= 1'b0;
      hld_r    <= 1'b0;
      mode_r   <= MODE_UP;
      presc_r  <= {TDW{1'b0}};
      hold_r   <= {CW{1'b0}};
      preset_r <= {CW{1'b0}};
      done_r   <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      done_r <= zero_ev_s;
      wrap_r <= wrap_ev_s;
      if (b_run) begin
        if (run_r) begin
          run_r <= 1'b0;
        end else if (start_ok_s) begin
          run_r  <= 1'b1;
          mode_r <= mode_in_s;
        end
      end else if (zero_ev_s) begin
        run_r <= 1'b0;
      end
      if (clr_ev_s) begin
        if (run_r) begin
          hld_r <= ~hld_r;
          if (!hld_r) begin
            hold_r <= count_s;
          end
        end else if (hld_r) begin
          hld_r <= 1'b0;
        end
      end
      if (ld_ev_s) begin
        preset_r <= ld_sat_s;
      end
      if (clr_stop_s | ld_ev_s) begin
        presc_r <= {TDW{1'b0}};
      end else if (run_r) begin
        presc_r <= tick_s ? {TDW{1'b0}} : presc_r + TDW'(1);
      end
    end
  end

`ifdef STOPWATCH_OVF_EN
  logic ovf_r;

  // Sticky overflow: set on up wrap, cleared only by a stopped clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (wrap_ev_s) begin
      ovf_r <= 1'b1;
    end else if (clr_stop_s) begin
      ovf_r <= 1'b0;
    end
  end

  assign ovf = ovf_r;
`endif

  assign dsp_bcd = hld_r ? hold_r : count_s;
  assign s_run   = run_r;
  assign s_hld   = hld_r;
  assign tick    = tick_s;
  assign done    = done_r;
  assign wrap    = wrap_r;

endmodule
